// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed active-low 7-segment driver for NUM_DIGITS hex
//            digits, with frame-consistent loading, blank mask and dead time.
// Option   : define SEG7_ZERO_BLANK_EN to blank leading zero digits.
// Revision : 1.0  initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEAD_CYC       = 16,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic [4*NUM_DIGITS-1:0] iDATA,
  input  logic                    iLOAD,
  input  logic [NUM_DIGITS-1:0]   iBLANK_MASK,
  output logic [6:0]              oSEG,
  output logic [NUM_DIGITS-1:0]   oDIG_SEL,
  output logic                    oFRAME
);

  localparam int unsigned           c_PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned           c_IW         = $clog2(NUM_DIGITS);
  localparam logic [c_PW-1:0]       c_PRESC_LAST = c_PW'(SCAN_DIV - 1);
  localparam logic [c_PW-1:0]       c_DEAD       = c_PW'(DEAD_CYC);
  localparam logic [c_IW-1:0]       c_IDX_LAST   = c_IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] c_SEL_OFF    = {NUM_DIGITS{DIG_ACTIVE_LOW}};
  localparam logic [6:0]            c_SEG_DARK   = 7'h7F;

  logic [c_PW-1:0]         presc_q, presc_d;
  logic [c_IW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] stage_q, stage_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    frame_q, frame_d;

  logic                    w_presc_tc;
  logic                    w_wrap;
  logic [3:0]              w_nib;
  logic                    w_mask_bit;
  logic                    w_lz_bit;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [NUM_DIGITS-1:0]   w_lz;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    f_decode = 7'h40;
      4'h1:    f_decode = 7'h79;
      4'h2:    f_decode = 7'h24;
      4'h3:    f_decode = 7'h30;
      4'h4:    f_decode = 7'h19;
      4'h5:    f_decode = 7'h12;
      4'h6:    f_decode = 7'h02;
      4'h7:    f_decode = 7'h78;
      4'h8:    f_decode = 7'h00;
      4'h9:    f_decode = 7'h18;
      4'hA:    f_decode = 7'h08;
      4'hB:    f_decode = 7'h03;
      4'hC:    f_decode = 7'h46;
      4'hD:    f_decode = 7'h21;
      4'hE:    f_decode = 7'h06;
      default: f_decode = 7'h0E;
    endcase
  endfunction

  assign w_presc_tc = (presc_q == c_PRESC_LAST);
  assign w_wrap     = w_presc_tc && (idx_q == c_IDX_LAST);

  // Scan timing and staging; display only swaps on the wrap edge so a frame
  // never mixes old and new data.
  always_comb begin
    presc_d = w_presc_tc ? '0 : presc_q + c_PW'(1);
    idx_d   = idx_q;
    if (w_presc_tc) begin
      idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + c_IW'(1);
    end
    disp_d  = w_wrap ? stage_q : disp_q;
    stage_d = iLOAD ? iDATA : stage_q;
    frame_d = w_wrap;
  end

`ifdef SEG7_ZERO_BLANK_EN
  always_comb begin : p_lead_zero
    logic v_above;
    w_lz    = '0;
    v_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      if (disp_q[4*k +: 4] != 4'h0) begin
        v_above = 1'b0;
      end
      w_lz[k] = v_above;
    end
  end
`else
  assign w_lz = '0;
`endif

  always_comb begin
    w_nib      = 4'h0;
    w_mask_bit = 1'b0;
    w_lz_bit   = 1'b0;
    w_onehot   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == c_IW'(k)) begin
        w_nib       = disp_q[4*k +: 4];
        w_mask_bit  = iBLANK_MASK[k];
        w_lz_bit    = w_lz[k];
        w_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    seg_d = c_SEG_DARK;
    sel_d = c_SEL_OFF;
    if (presc_q >= c_DEAD) begin
      sel_d = w_onehot ^ c_SEL_OFF;
      seg_d = (w_mask_bit || w_lz_bit) ? c_SEG_DARK : f_decode(w_nib);
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      presc_q <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      disp_q  <= '0;
      seg_q   <= c_SEG_DARK;
      sel_q   <= c_SEL_OFF;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      disp_q  <= disp_d;
      seg_q   <= seg_d;
      sel_q   <= sel_d;
      frame_q <= frame_d;
    end
  end

  assign oSEG     = seg_q;
  assign oDIG_SEL = sel_q;
  assign oFRAME   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Self-checking bench for seg7_scan_driver (4 digits, SCAN_DIV=8,
//            DEAD_CYC=2, active-low selects); honours SEG7_ZERO_BLANK_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DC = 2;
  localparam bit AL = 1'b1;
`ifdef SEG7_ZERO_BLANK_EN
  localparam bit ZB = 1'b1;
`else
  localparam bit ZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data = '0;
  logic        load = 1'b0;
  logic [3:0]  mask = '0;
  logic [6:0]  seg;
  logic [3:0]  sel;
  logic        frame;

  int total = 0;
  int bad   = 0;

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] sel_lit [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  seg7_scan_driver #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC), .DIG_ACTIVE_LOW(AL)
  ) dut (
    .iCLK(clk), .iRST(rst), .iDATA(data), .iLOAD(load), .iBLANK_MASK(mask),
    .oSEG(seg), .oDIG_SEL(sel), .oFRAME(frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: scan position is plain arithmetic on the cycle count
  int          m_cnt   = 0;
  logic [15:0] m_stage = '0;
  logic [15:0] m_disp  = '0;
  logic [6:0]  e_seg   = 7'h7F;
  logic [3:0]  e_sel   = 4'hF;
  logic        e_frame = 1'b0;

  function automatic bit lead_zero(input logic [15:0] d, input int k);
    int hi;
    hi = 0;
    for (int j = 0; j < ND; j++) if (d[4*j +: 4] != 4'h0) hi = j;
    return ZB && (k > hi);
  endfunction

  always @(posedge clk) begin : model
    int p, d;
    if (rst) begin
      m_cnt = 0; m_stage = '0; m_disp = '0;
      e_seg = 7'h7F; e_sel = AL ? 4'hF : 4'h0; e_frame = 1'b0;
    end else begin
      p = m_cnt % SD;
      d = (m_cnt / SD) % ND;
      if (p < DC) begin
        e_seg = 7'h7F;
        e_sel = AL ? 4'hF : 4'h0;
      end else begin
        e_sel = AL ? ~(4'b1 << d) : (4'b1 << d);
        e_seg = (mask[d] || lead_zero(m_disp, d)) ? 7'h7F : dec_tab[m_disp[4*d +: 4]];
      end
      e_frame = (((m_cnt + 1) % (SD * ND)) == 0);
      if (e_frame) m_disp = m_stage;
      if (load) m_stage = data;
      m_cnt++;
    end
  end

  always begin
    @(posedge clk);
    #2;
    check("cyc_seg", seg, e_seg);
    check("cyc_sel", sel, e_sel);
    check("cyc_frame", frame, e_frame);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_frame(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (frame !== 1'b1 && n < 64);
    check(tag, frame, 1);
  endtask

  // Assert reset now, check outputs go dark at once, then time the first frame
  task automatic reset_and_time(input string tag);
    int n;
    rst  = 1'b1;
    load = 1'b0;
    #1;
    check({tag, "_rst_seg"}, seg, 7'h7F);
    check({tag, "_rst_sel"}, sel, 4'hF);
    check({tag, "_rst_frame"}, frame, 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (frame !== 1'b1 && n < 100);
    check({tag, "_first_frame_cycles"}, n, 32);
  endtask

  // From a frame-pulse negedge, walk one frame and pin each slot to literals
  task automatic frame_expect(input string tag, input logic [27:0] exp);
    int s;
    for (int e = 1; e <= SD * ND; e++) begin
      step();
      s = (e - 1) / SD;
      if ((e - 1) % SD == 0) begin
        check({tag, "_dead_seg"}, seg, 7'h7F);
        check({tag, "_dead_sel"}, sel, 4'hF);
      end
      if ((e - 1) % SD == DC) begin
        check({tag, "_seg"}, seg, exp[7*s +: 7]);
        check({tag, "_sel"}, sel, sel_lit[s]);
      end
    end
    check({tag, "_frame"}, frame, 1);
  endtask

  initial begin
    rst = 1'b1;
    reset_and_time("init");
    frame_expect("zeros", {7'h40, 7'h40, 7'h40, 7'h40});

    repeat (5) step();
    data = 16'h1A3F; load = 1'b1;
    step();
    load = 1'b0;
    wait_frame("mid_load_wait");
    frame_expect("d1A3F", {7'h79, 7'h08, 7'h30, 7'h0E});

    repeat (SD * ND - 1) step();
    data = 16'h2B4C; load = 1'b1;
    step();
    load = 1'b0;
    check("load_on_wrap_frame", frame, 1);
    frame_expect("old_after_wrap_load", {7'h79, 7'h08, 7'h30, 7'h0E});
    frame_expect("d2B4C", {7'h24, 7'h03, 7'h19, 7'h46});

    mask = 4'b0100;
    frame_expect("mask2", {7'h24, 7'h7F, 7'h19, 7'h46});
    mask = 4'b0000;

    if (ZB) begin
      data = 16'h0050; load = 1'b1;
      step();
      load = 1'b0;
      wait_frame("zb_wait1");
      frame_expect("zb0050", {7'h7F, 7'h7F, 7'h12, 7'h40});
      data = 16'h0000; load = 1'b1;
      step();
      load = 1'b0;
      wait_frame("zb_wait2");
      frame_expect("zb0000", {7'h7F, 7'h7F, 7'h7F, 7'h40});
    end

    repeat (2 * SD + 4) step();
    check("digit2_before_rst", sel, 4'hB);
    reset_and_time("mid_rst");
    frame_expect("after_rst", {7'h40, 7'h40, 7'h40, 7'h40});

    for (int i = 0; i < 900; i++) begin
      data = 16'($urandom);
      load = ($urandom_range(0, 5) == 0);
      mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 299) == 0) reset_and_time("rand_rst");
      else step();
    end

    load = 1'b0;
    mask = 4'h0;
    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
